// File: rtl/oled_frame_ctrl.sv
// rtl/oled_frame_ctrl.sv - full-screen OLED refresh sequencer (command window + framebuffer stream); optional OLED_AUTO_REFRESH_EN
module oled_frame_ctrl #(
    parameter int         FB_BYTES       = 8192,
    parameter int         FB_ADDR_W      = 13,
    parameter logic [7:0] COL_START      = 8'h1C,
    parameter logic [7:0] COL_END        = 8'h5B,
    parameter logic [7:0] ROW_START      = 8'h00,
    parameter logic [7:0] ROW_END        = 8'h3F,
    parameter int         REFRESH_CYCLES = 833333
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init_done,
    input  logic                 start,
    output logic                 busy,
    output logic                 frame_done,
    output logic [FB_ADDR_W-1:0] fb_addr,
    input  logic [7:0]           fb_data,
    output logic                 oled_cs,
    output logic                 oled_e,
    output logic                 oled_rw,
    output logic                 oled_dc,
    output logic [7:0]           oled_dout
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD_LOAD = 3'd1,
        CMD_SEND = 3'd2,
        PIX_LOAD = 3'd3,
        PIX_SEND = 3'd4,
        FINISH   = 3'd5
    } state_t;

    // Pixel counter carries one extra bit so reaching FB_BYTES never wraps to 0.
    localparam logic [FB_ADDR_W:0] FB_COUNT = (FB_ADDR_W+1)'(FB_BYTES);
    localparam logic [2:0]         CMD_LEN  = 3'd7;

    state_t               state, state_nxt;
    logic [2:0]           cmd_idx, cmd_idx_nxt;
    logic [FB_ADDR_W:0]   pix_cnt, pix_cnt_nxt;
    logic                 cs_nxt, e_nxt, dc_nxt, busy_nxt, frame_done_nxt;
    logic [7:0]           dout_nxt;
    logic                 eff_start;
    logic                 accept;

    // Window/write-RAM command list: {dc, byte}; opcodes carry dc=0, arguments dc=1.
    function automatic logic [8:0] cmd_word(input logic [2:0] i);
        case (i)
            3'd0:    cmd_word = {1'b0, 8'h15};
            3'd1:    cmd_word = {1'b1, COL_START};
            3'd2:    cmd_word = {1'b1, COL_END};
            3'd3:    cmd_word = {1'b0, 8'h75};
            3'd4:    cmd_word = {1'b1, ROW_START};
            3'd5:    cmd_word = {1'b1, ROW_END};
            default: cmd_word = {1'b0, 8'h5C};
        endcase
    endfunction

`ifdef OLED_AUTO_REFRESH_EN
    localparam int RC_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_CYCLES - 1);

    logic [RC_W-1:0] refresh_cnt;
    logic            refresh_tick;
    logic            pending;

    assign refresh_tick = init_done && (refresh_cnt == RC_LAST);

    // Refresh timer runs only after init; every wrap folds into a single pending request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            pending     <= 1'b0;
        end else begin
            if (!init_done || refresh_tick) begin
                refresh_cnt <= '0;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            pending <= refresh_tick | (pending & ~accept);
        end
    end

    assign eff_start = start | pending;
`else
    logic cfg_unused;
    assign cfg_unused = (REFRESH_CYCLES > 0);
    assign eff_start  = start;
`endif

    assign accept    = (state == IDLE) && eff_start && init_done;
    assign fb_addr   = pix_cnt[FB_ADDR_W-1:0];
    assign oled_rw   = 1'b0;

    // State and registered bus/datapath outputs; async reset aborts a frame immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cmd_idx    <= '0;
            pix_cnt    <= '0;
            oled_cs    <= 1'b1;
            oled_e     <= 1'b1;
            oled_dc    <= 1'b0;
            oled_dout  <= 8'h00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cmd_idx    <= cmd_idx_nxt;
            pix_cnt    <= pix_cnt_nxt;
            oled_cs    <= cs_nxt;
            oled_e     <= e_nxt;
            oled_dc    <= dc_nxt;
            oled_dout  <= dout_nxt;
            busy       <= busy_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    // Next-state: alternate load/send per byte, commands first, then the framebuffer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = CMD_LOAD;
            CMD_LOAD: state_nxt = CMD_SEND;
            CMD_SEND: state_nxt = (cmd_idx < CMD_LEN) ? CMD_LOAD : PIX_LOAD;
            PIX_LOAD: state_nxt = PIX_SEND;
            PIX_SEND: state_nxt = (pix_cnt < FB_COUNT) ? PIX_LOAD : FINISH;
            FINISH:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Output/datapath next values: e high in LOAD, falls in SEND to latch the byte.
    always_comb begin
        cmd_idx_nxt    = cmd_idx;
        pix_cnt_nxt    = pix_cnt;
        cs_nxt         = oled_cs;
        e_nxt          = oled_e;
        dc_nxt         = oled_dc;
        dout_nxt       = oled_dout;
        busy_nxt       = busy;
        frame_done_nxt = 1'b0;
        case (state)
            IDLE: begin
                cs_nxt = 1'b1;
                e_nxt  = 1'b1;
                if (accept) begin
                    cs_nxt      = 1'b0;
                    busy_nxt    = 1'b1;
                    pix_cnt_nxt = '0;
                    cmd_idx_nxt = '0;
                end
            end
            CMD_LOAD: begin
                e_nxt              = 1'b1;
                {dc_nxt, dout_nxt} = cmd_word(cmd_idx);
                cmd_idx_nxt        = cmd_idx + 1'b1;
            end
            CMD_SEND: begin
                e_nxt = 1'b0;
            end
            PIX_LOAD: begin
                e_nxt       = 1'b1;
                dc_nxt      = 1'b1;
                dout_nxt    = fb_data;
                pix_cnt_nxt = pix_cnt + 1'b1;
            end
            PIX_SEND: begin
                e_nxt = 1'b0;
            end
            FINISH: begin
                cs_nxt         = 1'b1;
                e_nxt          = 1'b1;
                busy_nxt       = 1'b0;
                frame_done_nxt = 1'b1;
            end
            default: begin
                cs_nxt   = 1'b1;
                e_nxt    = 1'b1;
                busy_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_oled_frame_ctrl.sv
// tb/tb_oled_frame_ctrl.sv - self-checking bench for oled_frame_ctrl
module tb_oled_frame_ctrl;
    localparam int FB_BYTES       = 4;
    localparam int FB_ADDR_W      = 2;
    localparam int REFRESH_CYCLES = 64;
    localparam int FRAME_LEN      = 7 + FB_BYTES;
    localparam int LATENCY        = 2 * FB_BYTES + 15;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 init_done = 1'b0;
    logic                 start = 1'b0;
    logic                 busy, frame_done;
    logic [FB_ADDR_W-1:0] fb_addr;
    logic [7:0]           fb_data = 8'h00;
    logic                 oled_cs, oled_e, oled_rw, oled_dc;
    logic [7:0]           oled_dout;

    oled_frame_ctrl #(
        .FB_BYTES(FB_BYTES), .FB_ADDR_W(FB_ADDR_W), .REFRESH_CYCLES(REFRESH_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .init_done(init_done), .start(start),
        .busy(busy), .frame_done(frame_done), .fb_addr(fb_addr), .fb_data(fb_data),
        .oled_cs(oled_cs), .oled_e(oled_e), .oled_rw(oled_rw), .oled_dc(oled_dc),
        .oled_dout(oled_dout)
    );

    always #5 clk = ~clk;

    // framebuffer model: mem[i] = A0+i, synchronous read
    always @(posedge clk) fb_data <= 8'hA0 + 8'(fb_addr);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // bus monitor: capture {dc,dout} at every falling e while selected
    logic [8:0] got_q[$];
    int         fd_cyc[$];
    int         cs_low_noinit = 0;
    int         rw_bad = 0;
    logic       prev_e = 1'b1;

    always @(negedge clk) begin
        if (oled_rw !== 1'b0) rw_bad++;
        if (oled_cs === 1'b0 && init_done === 1'b0) cs_low_noinit++;
        if (prev_e === 1'b1 && oled_e === 1'b0 && oled_cs === 1'b0)
            got_q.push_back({oled_dc, oled_dout});
        if (frame_done === 1'b1) fd_cyc.push_back(cyc);
        prev_e = oled_e;
    end

    // reference frame built from the command list and framebuffer contents
    logic [8:0] exp_frame[FRAME_LEN];

    function automatic int model_frames(input bit init, input int off);
        // a second start is honoured only once the first frame has left FINISH
        if (!init) return 0;
        return (off >= LATENCY + 1) ? 2 : 1;
    endfunction

    task automatic clear_mon();
        got_q.delete();
        fd_cyc.delete();
        cs_low_noinit = 0;
    endtask

    task automatic run_case(input string tag, input bit init, input int off,
                            input int exp_frames);
        int s;
        clear_mon();
        @(negedge clk);
        init_done = init;
        start = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        if (off > 0) begin
            repeat (off - 1) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        repeat (60) @(negedge clk);
        check({tag, " frames"}, fd_cyc.size(), exp_frames);
        check({tag, " bytes"}, got_q.size(), exp_frames * FRAME_LEN);
        for (int i = 0; i < got_q.size() && i < exp_frames * FRAME_LEN; i++)
            check($sformatf("%s byte%0d", tag, i), got_q[i], exp_frame[i % FRAME_LEN]);
        if (exp_frames > 0 && fd_cyc.size() > 0)
            check({tag, " latency"}, fd_cyc[0] - s, LATENCY);
        check({tag, " cs_idle"}, oled_cs, 1'b1);
        check({tag, " busy_idle"}, busy, 1'b0);
        if (!init) check({tag, " cs_noinit"}, cs_low_noinit, 0);
    endtask

    typedef struct {
        bit init;
        int off;
        int frames;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int s;
        int n0;
        int f;
        exp_frame[0] = {1'b0, 8'h15};
        exp_frame[1] = {1'b1, 8'h1C};
        exp_frame[2] = {1'b1, 8'h5B};
        exp_frame[3] = {1'b0, 8'h75};
        exp_frame[4] = {1'b1, 8'h00};
        exp_frame[5] = {1'b1, 8'h3F};
        exp_frame[6] = {1'b0, 8'h5C};
        for (int i = 0; i < FB_BYTES; i++) exp_frame[7+i] = {1'b1, 8'hA0 + 8'(i)};

        // {init_done, second-start offset (0 = none), expected frames}
        tbl[0] = '{0, 0, 0};
        tbl[1] = '{1, 0, 1};
        tbl[2] = '{1, 1, 1};
        tbl[3] = '{1, 16, 1};
        tbl[4] = '{1, 23, 1};
        tbl[5] = '{1, 24, 2};
        tbl[6] = '{1, 25, 2};

        repeat (2) @(negedge clk);
        check("rst cs", oled_cs, 1'b1);
        check("rst e", oled_e, 1'b1);
        check("rst rw", oled_rw, 1'b0);
        check("rst dc", oled_dc, 1'b0);
        check("rst dout", oled_dout, 8'h00);
        check("rst busy", busy, 1'b0);
        check("rst frame_done", frame_done, 1'b0);
        check("rst fb_addr", fb_addr, 0);
        rst = 1'b0;

`ifndef OLED_AUTO_REFRESH_EN
        for (int t = 0; t < 7; t++)
            run_case($sformatf("vec%0d", t), tbl[t].init, tbl[t].off, tbl[t].frames);

        for (int r = 0; r < 6; r++) begin
            int off;
            off = $urandom_range(1, 30);
            run_case($sformatf("rnd%0d_off%0d", r, off), 1'b1, off, model_frames(1'b1, off));
        end

        // reset asserted during PIX_LOAD of the second pixel
        clear_mon();
        @(negedge clk);
        start = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        check("midrst sync", cyc - s, 16);
        rst = 1'b1;
        #1;
        check("midrst cs", oled_cs, 1'b1);
        check("midrst e", oled_e, 1'b1);
        check("midrst dc", oled_dc, 1'b0);
        check("midrst busy", busy, 1'b0);
        check("midrst bytes", got_q.size(), 8);
        if (got_q.size() >= 8) check("midrst last", got_q[7], {1'b1, 8'hA0});
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst no_done", fd_cyc.size(), 0);
        run_case("postrst", 1'b1, 0, 1);
`else
        run_case("noinit", 1'b0, 0, 0);
        clear_mon();
        @(negedge clk);
        init_done = 1'b1;
        repeat (300) @(negedge clk);
        check("auto frames", fd_cyc.size() >= 4, 1'b1);
        if (fd_cyc.size() >= 3) begin
            check("auto period1", fd_cyc[1] - fd_cyc[0], REFRESH_CYCLES);
            check("auto period2", fd_cyc[2] - fd_cyc[1], REFRESH_CYCLES);
        end
        n0 = fd_cyc.size();
        for (int i = 0; i < 200 && fd_cyc.size() == n0; i++) @(negedge clk);
        check("auto wait", fd_cyc.size() > n0, 1'b1);
        f = cyc;
        repeat (29) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n0 = fd_cyc.size();
        while (cyc < f + 110) @(negedge clk);
        check("auto merge", fd_cyc.size() - n0, 2);
`endif

        check("rw never high", rw_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
